// File: rtl/ft60x_fifo_bridge.sv
// FT60x 245-style synchronous FIFO bridge: arbitrates USB read/write bursts onto RX/TX streams.
// Optional word counters on rx_count/tx_count are built only when FT60X_STATS_EN is defined.
module ft60x_fifo_bridge #(
    parameter int DATA_W     = 32,
    parameter int RX_DEPTH   = 4,
    parameter int MAX_BURST  = 64,
    parameter int RST_CYCLES = 16,
    localparam int BE_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              usb_txe_l,
    input  logic              usb_rxf_l,
    output logic              usb_wr_l,
    output logic              usb_rd_l,
    output logic              usb_oe_l,
    output logic              usb_rst_l,
    inout  wire  [DATA_W-1:0] usb_data,
    inout  wire  [BE_W-1:0]   usb_be,
    output logic [DATA_W-1:0] rx_data,
    output logic [BE_W-1:0]   rx_be,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [BE_W-1:0]   tx_be,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [31:0]       rx_count,
    output logic [31:0]       tx_count
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {RST_HOLD, IDLE, RD_OE, RD_DATA, WR_DATA, TURN} state_t;
    state_t state;

    logic [RW-1:0]     rst_cnt;
    logic [BW-1:0]     burst;
    logic              prio_rd;

    // RX FIFO
    logic [DATA_W-1:0] fifo_data [RX_DEPTH];
    logic [BE_W-1:0]   fifo_be   [RX_DEPTH];
    logic [AW:0]       wp, rp, fill, free_cnt;
    logic              cap, pop, rd_req, rd_stop;
    logic [BW-1:0]     rd_burst_n;

    assign fill     = wp - rp;
    assign free_cnt = (AW+1)'(RX_DEPTH) - fill;
    assign rx_valid = (fill != '0);
    assign rx_data  = fifo_data[rp[AW-1:0]];
    assign rx_be    = fifo_be[rp[AW-1:0]];
    assign cap      = !usb_rd_l && !usb_oe_l && !usb_rxf_l;
    assign pop      = rx_valid && rx_ready;

    assign rd_req     = !usb_rxf_l && (free_cnt >= (AW+1)'(2));
    assign rd_burst_n = burst + BW'(cap);
    // free_cnt excludes this cycle's capture: with one slot left, that word takes it and rd_l rises
    assign rd_stop    = usb_rxf_l || (free_cnt < (AW+1)'(2)) || (rd_burst_n == BW'(MAX_BURST));

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (cap) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            fifo_data[wp[AW-1:0]] <= usb_data;
            fifo_be[wp[AW-1:0]]   <= usb_be;
        end
    end

    // TX output register; a word stays here until the bus accepts it
    logic [DATA_W-1:0] wr_data_q;
    logic [BE_W-1:0]   wr_be_q;
    logic              wr_full, wr_full_n, wr_cpl, tx_load, wr_req, wr_stop;
    logic [BW-1:0]     wr_burst_n;

    assign wr_cpl     = !usb_wr_l && !usb_txe_l;
    assign tx_ready   = (state == WR_DATA) && (!wr_full || wr_cpl);
    assign tx_load    = tx_valid && tx_ready;
    assign wr_full_n  = tx_load || (wr_full && !wr_cpl);
    assign wr_req     = !usb_txe_l && (tx_valid || wr_full);
    assign wr_burst_n = burst + BW'(wr_cpl);
    assign wr_stop    = ((!wr_full || wr_cpl) && !tx_valid) || usb_txe_l ||
                        (wr_burst_n == BW'(MAX_BURST));

    assign usb_data = usb_wr_l ? 'z : wr_data_q;
    assign usb_be   = usb_wr_l ? 'z : wr_be_q;

    always_ff @(posedge clk) begin
        if (tx_load) begin
            wr_data_q <= tx_data;
            wr_be_q   <= tx_be;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= RST_HOLD;
            rst_cnt   <= '0;
            burst     <= '0;
            prio_rd   <= 1'b1;
            wr_full   <= 1'b0;
            usb_rst_l <= 1'b0;
            usb_wr_l  <= 1'b1;
            usb_rd_l  <= 1'b1;
            usb_oe_l  <= 1'b1;
        end else begin
            wr_full <= wr_full_n;
            case (state)
                RST_HOLD: begin
                    if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                        usb_rst_l <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (rd_req && (!wr_req || prio_rd)) begin
                        usb_oe_l <= 1'b0;
                        burst    <= '0;
                        prio_rd  <= 1'b0;
                        state    <= RD_OE;
                    end else if (wr_req) begin
                        usb_wr_l <= !wr_full;
                        burst    <= '0;
                        prio_rd  <= 1'b1;
                        state    <= WR_DATA;
                    end
                end
                RD_OE: begin
                    usb_rd_l <= 1'b0;
                    state    <= RD_DATA;
                end
                RD_DATA: begin
                    burst <= rd_burst_n;
                    if (rd_stop) begin
                        usb_rd_l <= 1'b1;
                        usb_oe_l <= 1'b1;
                        state    <= TURN;
                    end
                end
                WR_DATA: begin
                    burst <= wr_burst_n;
                    if (wr_stop) begin
                        usb_wr_l <= 1'b1;
                        state    <= TURN;
                    end else begin
                        usb_wr_l <= !wr_full_n;
                    end
                end
                TURN:    state <= IDLE;
                default: state <= RST_HOLD;
            endcase
        end
    end

`ifdef FT60X_STATS_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            rx_count <= rx_count + 32'(cap);
            tx_count <= tx_count + 32'(wr_cpl);
        end
    end
`else
    assign rx_count = '0;
    assign tx_count = '0;
`endif

endmodule

// File: tb/tb_ft60x_fifo_bridge.sv
// Directed bench for ft60x_fifo_bridge: FT60x-side model, RX sink, TX source and burst monitor.
module tb_ft60x_fifo_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_l, usb_txe_l, rxf_force, rx_ready, tx_en, mclr;
    logic        usb_rxf_l, usb_wr_l, usb_rd_l, usb_oe_l, usb_rst_l;
    wire  [31:0] usb_data;
    wire  [3:0]  usb_be;
    logic [31:0] rx_data, tx_data, rx_count, tx_count;
    logic [3:0]  rx_be, tx_be;
    logic        rx_valid, tx_valid, tx_ready;

    logic [31:0] rx_src [32];
    logic [31:0] tx_src [32];
    int          rx_n, tx_n;
    logic [7:0]  rx_idx, tx_idx;
    logic [31:0] track;

    assign usb_rxf_l = rxf_force || (int'(rx_idx) >= rx_n);
    assign usb_data  = usb_oe_l ? 'z : rx_src[rx_idx[4:0]];
    assign usb_be    = usb_oe_l ? 'z : (4'hF ^ rx_idx[3:0]);
    assign tx_valid  = tx_en && (int'(tx_idx) < tx_n);
    assign tx_data   = tx_src[tx_idx[4:0]];
    assign tx_be     = 4'hF ^ tx_idx[3:0];

    ft60x_fifo_bridge #(.DATA_W(32), .RX_DEPTH(4), .MAX_BURST(4), .RST_CYCLES(16)) dut (
        .clk(clk), .rst_l(rst_l),
        .usb_txe_l(usb_txe_l), .usb_rxf_l(usb_rxf_l),
        .usb_wr_l(usb_wr_l), .usb_rd_l(usb_rd_l), .usb_oe_l(usb_oe_l), .usb_rst_l(usb_rst_l),
        .usb_data(usb_data), .usb_be(usb_be),
        .rx_data(rx_data), .rx_be(rx_be), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_be(tx_be), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_count(rx_count), .tx_count(tx_count)
    );

    // bus-side monitor and models
    logic        cap_m, cpl_m, pop_m, ev_m;
    logic [31:0] got [32];
    logic [3:0]  got_be [32];
    logic [31:0] bus [32];
    logic [3:0]  bus_be [32];
    int          got_n, bus_n, overlap, oe_only, pres, occ, max_occ, occ_n;
    int          n_runs, cur_len, cyc, last_ev;
    logic        started, cur_dir;
    int          run_len [8];
    int          run_gap [8];
    logic        run_dir [8];

    assign cap_m = !usb_rd_l && !usb_oe_l && !usb_rxf_l;
    assign cpl_m = !usb_wr_l && !usb_txe_l;
    assign pop_m = rx_valid && rx_ready;
    assign ev_m  = cap_m || cpl_m;
    assign occ_n = occ + int'(cap_m) - int'(pop_m);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mclr) begin
            rx_idx <= '0; tx_idx <= '0; got_n <= 0; bus_n <= 0;
            overlap <= 0; oe_only <= 0; pres <= 0; occ <= 0; max_occ <= 0;
            n_runs <= 0; cur_len <= 0; started <= 1'b0; cur_dir <= 1'b0; last_ev <= 0;
        end else begin
            if (cap_m) rx_idx <= rx_idx + 1'b1;
            if (tx_valid && tx_ready) tx_idx <= tx_idx + 1'b1;
            if (pop_m && got_n < 32) begin
                got[got_n]    <= rx_data;
                got_be[got_n] <= rx_be;
                got_n         <= got_n + 1;
            end
            if (cpl_m && bus_n < 32) begin
                bus[bus_n]    <= usb_data;
                bus_be[bus_n] <= usb_be;
                bus_n         <= bus_n + 1;
            end
            if (!usb_rd_l && !usb_wr_l) overlap <= overlap + 1;
            if (!usb_oe_l && usb_rd_l) oe_only <= oe_only + 1;
            if (!usb_wr_l && usb_data == track) pres <= pres + 1;
            occ <= occ_n;
            if (occ_n > max_occ) max_occ <= occ_n;
            if (ev_m) begin
                if (started && cpl_m == cur_dir) begin
                    cur_len <= cur_len + 1;
                end else begin
                    if (started && n_runs < 8) begin
                        run_len[n_runs] <= cur_len;
                        run_dir[n_runs] <= cur_dir;
                        run_gap[n_runs] <= cyc - last_ev;
                        n_runs          <= n_runs + 1;
                    end
                    cur_dir <= cpl_m;
                    cur_len <= 1;
                    started <= 1'b1;
                end
                last_ev <= cyc;
            end
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
        end
    endtask

    task automatic pulse_mclr();
        mclr = 1'b1;
        @(negedge clk);
        mclr = 1'b0;
    endtask

    // counts posedges from reset release until usb_rst_l rises
    task automatic rst_hold_check(input string tag);
        int n, bad;
        n = 0; bad = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!usb_wr_l || !usb_rd_l || !usb_oe_l) bad++;
        end while (!usb_rst_l && n < 100);
        chk({tag, "_len"}, n, 16);
        chk({tag, "_strobes"}, bad, 0);
    endtask

    initial begin
        cyc = 0;
        for (int i = 0; i < 32; i++) begin
            rx_src[i] = 32'h11111111 * 32'(i + 1);
            tx_src[i] = 32'hA5A50000 + 32'(i);
        end
        rst_l = 1'b0; usb_txe_l = 1'b1; rxf_force = 1'b1; rx_ready = 1'b0;
        tx_en = 1'b0; mclr = 1'b1; rx_n = 0; tx_n = 0; track = 32'hDEADBEEF;

        // reset values and RST_HOLD length
        repeat (3) @(negedge clk);
        chk("rst_usb_rst_l", usb_rst_l, 0);
        chk("rst_wr_l", usb_wr_l, 1);
        chk("rst_rd_l", usb_rd_l, 1);
        chk("rst_oe_l", usb_oe_l, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_count", rx_count, 0);
        mclr = 1'b0;
        rst_l = 1'b1;
        rst_hold_check("rst_hold");

        // three-word read with sink ready
        @(negedge clk);
        rx_n = 3; rx_ready = 1'b1;
        pulse_mclr();
        rxf_force = 1'b0;
        for (int i = 0; i < 50 && got_n < 3; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("rd3_n", got_n, 3);
        chk("rd3_w0", got[0], 32'h11111111);
        chk("rd3_w1", got[1], 32'h22222222);
        chk("rd3_w2", got[2], 32'h33333333);
        chk("rd3_be0", got_be[0], 4'hF);
        chk("rd3_be1", got_be[1], 4'hE);
        chk("rd3_oe_lead", oe_only, 1);
`ifdef FT60X_STATS_EN
        chk("rd3_rx_count", rx_count, 3);
`else
        chk("rd3_rx_count", rx_count, 0);
`endif

        // ten-word read with backpressure: FIFO fills to 4 and stops
        rx_ready = 1'b0; rx_n = 10;
        pulse_mclr();
        repeat (30) @(negedge clk);
        chk("bp_popped", got_n, 0);
        chk("bp_captured", rx_idx, 4);
        chk("bp_rd_l", usb_rd_l, 1);
        chk("bp_rx_valid", rx_valid, 1);
        chk("bp_occ", max_occ, 4);
        rx_ready = 1'b1;
        for (int i = 0; i < 200 && got_n < 10; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("bp_n", got_n, 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("bp_w%0d", i), got[i], 32'h11111111 * 32'(i + 1));
        chk("bp_max_occ", max_occ, 4);
`ifdef FT60X_STATS_EN
        chk("bp_rx_count", rx_count, 13);
`else
        chk("bp_rx_count", rx_count, 0);
`endif

        // five-word write, txe_l pulsed while word 3 is on the bus
        rxf_force = 1'b1; rx_n = 0; tx_n = 5; track = 32'hA5A50002;
        pulse_mclr();
        usb_txe_l = 1'b0; tx_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!usb_wr_l && usb_data == track) break;
        end
        usb_txe_l = 1'b1;
        @(negedge clk);
        usb_txe_l = 1'b0;
        for (int i = 0; i < 50 && bus_n < 5; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("wr5_n", bus_n, 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("wr5_w%0d", i), bus[i], 32'hA5A50000 + 32'(i));
        chk("wr5_be0", bus_be[0], 4'hF);
        chk("wr5_be1", bus_be[1], 4'hE);
        chk("wr5_w3_present", pres, 2);
`ifdef FT60X_STATS_EN
        chk("wr5_tx_count", tx_count, 5);
`else
        chk("wr5_tx_count", tx_count, 0);
`endif
        tx_en = 1'b0;

        // both directions requesting: alternating bursts of MAX_BURST
        rx_n = 16; tx_n = 16; track = 32'hDEADBEEF;
        pulse_mclr();
        rxf_force = 1'b0; tx_en = 1'b1; rx_ready = 1'b1;
        for (int i = 0; i < 200 && n_runs < 3; i++) @(negedge clk);
        chk("rr_runs", n_runs >= 3, 1);
        chk("rr0_dir", run_dir[0], 0);
        chk("rr0_len", run_len[0], 4);
        chk("rr0_gap", run_gap[0], 4);
        chk("rr1_dir", run_dir[1], 1);
        chk("rr1_len", run_len[1], 4);
        chk("rr1_gap", run_gap[1], 4);
        chk("rr2_dir", run_dir[2], 0);
        chk("rr2_len", run_len[2], 4);
        chk("rr_overlap", overlap, 0);
        tx_en = 1'b0; rxf_force = 1'b1;
        repeat (20) @(negedge clk);

        // reset asserted in the middle of a write burst
        tx_n = 16;
        pulse_mclr();
        tx_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!usb_wr_l) break;
        end
        chk("mid_wr_active", usb_wr_l, 0);
        #2 rst_l = 1'b0;
        #1;
        chk("mid_rst_wr_l", usb_wr_l, 1);
        chk("mid_rst_usb_rst_l", usb_rst_l, 0);
        chk("mid_rst_tx_ready", tx_ready, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_tx_count", tx_count, 0);
        tx_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        rst_hold_check("rehold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
